mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-port bundle shared by the fetch/data arbiter and its environment.
// slave: arbiter view; master: requester + memory view.
interface mem_arbiter_if;
  localparam int unsigned DW = 32;

  logic          if_req;
  logic [DW-1:0] if_addr;
  logic          if_ready;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [DW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between an instruction-fetch port and a data port.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);
  localparam int unsigned CW = 4;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] starve, starve_n;
  logic          gnt_d, gnt_d_n;
  logic          we_q, we_n;
  logic [DW-1:0] addr_n, wdata_n;
  logic          pick_d;
  logic          last_beat;

  // Next-state, grant selection and latch values
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    starve_n  = starve;
    gnt_d_n   = gnt_d;
    we_n      = we_q;
    addr_n    = bus.mem_addr;
    wdata_n   = bus.mem_wdata;
    pick_d    = 1'b0;
    last_beat = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          pick_d  = bus.d_req && !(bus.if_req && (starve == CW'(STARVE_LIMIT)));
          state_n = BUSY;
          cnt_n   = CW'(WAIT_CYCLES);
          gnt_d_n = pick_d;
          if (pick_d) begin
            we_n    = bus.d_we;
            addr_n  = bus.d_addr;
            wdata_n = bus.d_wdata;
            if (!bus.if_req)
              starve_n = '0;
            else if (starve != CW'(STARVE_LIMIT))
              starve_n = starve + 1'b1;
          end else begin
            we_n     = 1'b0;
            addr_n   = bus.if_addr;
            wdata_n  = '0;
            starve_n = '0;
          end
        end
      end
      BUSY: begin
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          last_beat = 1'b1;
          state_n   = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; outputs are derived from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      starve        <= '0;
      gnt_d         <= 1'b0;
      we_q          <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_ready  <= 1'b0;
      bus.d_ready   <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
      bus.busy      <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      starve        <= starve_n;
      gnt_d         <= gnt_d_n;
      we_q          <= we_n;
      bus.mem_addr  <= addr_n;
      bus.mem_wdata <= wdata_n;
      bus.mem_en    <= (state_n == BUSY);
      bus.mem_we    <= (state_n == BUSY) && we_n;
      bus.busy      <= (state_n != IDLE);
      bus.if_ready  <= (state_n == DONE) && !gnt_d_n;
      bus.d_ready   <= (state_n == DONE) && gnt_d_n;
      if (last_beat && !gnt_d)
        bus.if_rdata <= bus.mem_rdata;
      if (last_beat && gnt_d && !we_q)
        bus.d_rdata <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int unsigned W  = 2;
  localparam int unsigned SL = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(SL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  // Reference model: t = cycles elapsed since the grant edge (0 = idle)
  int unsigned t;
  int unsigned starve;
  bit          m_data, m_we;
  logic [31:0] m_addr, m_wdata, e_if_rdata, e_d_rdata;

  bit    f_end, d_end;
  int    rate_f, rate_d;
  string log_s;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=\"%s\" want=\"%s\"", name, act, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; starve = 0; m_data = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven
  task automatic model_edge();
    if (t == 0) begin
      if (bus.if_req || bus.d_req) begin
        m_data = bus.d_req && !(bus.if_req && starve == SL);
        if (m_data) begin
          m_addr = bus.d_addr; m_we = bus.d_we; m_wdata = bus.d_wdata;
          starve = bus.if_req ? ((starve + 1 > SL) ? SL : starve + 1) : 0;
        end else begin
          m_addr = bus.if_addr; m_we = 0; starve = 0;
        end
        t = 1;
      end
    end else if (t == W + 1) begin
      t = 0;
    end else begin
      t++;
      if (t == W + 1) begin
        if (!m_data)   e_if_rdata = ref_rd(m_addr);
        else if (m_we) ref_mem[m_addr] = m_wdata;
        else           e_d_rdata = ref_rd(m_addr);
      end
    end
  endtask

  task automatic compare_all();
    logic acc, rdy;
    acc = (t >= 1) && (t <= W);
    rdy = (t == W + 1);
    chk1("busy", bus.busy, t != 0);
    chk1("mem_en", bus.mem_en, acc);
    chk1("mem_we", bus.mem_we, acc && m_we);
    chk1("if_ready", bus.if_ready, rdy && !m_data);
    chk1("d_ready", bus.d_ready, rdy && m_data);
    chk1("ready_excl", bus.if_ready & bus.d_ready, 1'b0);
    chk32("if_rdata", bus.if_rdata, e_if_rdata);
    chk32("d_rdata", bus.d_rdata, e_d_rdata);
    if (t != 0) chk32("mem_addr", bus.mem_addr, m_addr);
    if (acc && m_we) chk32("mem_wdata", bus.mem_wdata, m_wdata);
  endtask

  // Requesters drop at the edge ending their ready cycle, then may re-request
  task automatic react();
    if (f_end) begin bus.if_req = 1'b0; f_end = 0; end
    if (d_end) begin bus.d_req = 1'b0; d_end = 0; end
    if (!bus.if_req && $urandom_range(0, 99) < rate_f) begin
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0040_0000 + 4 * $urandom_range(0, 255);
    end
    if (!bus.d_req && $urandom_range(0, 99) < rate_d) begin
      bus.d_req   = 1'b1;
      bus.d_we    = 1'($urandom_range(0, 1));
      bus.d_addr  = 32'h1001_0000 + 4 * $urandom_range(0, 15);
      bus.d_wdata = $urandom();
    end
    if (t == W + 1) begin
      if (m_data) d_end = 1;
      else        f_end = 1;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    compare_all();
    if (bus.if_ready) log_s = {log_s, "i"};
    if (bus.d_ready)  log_s = {log_s, "d"};
    if (bus.mem_en && bus.mem_we) env_mem[bus.mem_addr] = bus.mem_wdata;
    bus.mem_rdata = env_rd(bus.mem_addr);
    react();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    bus.if_req = 1'b0; bus.d_req = 1'b0; f_end = 0; d_end = 0;
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_mem_en", bus.mem_en, 1'b0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);
    chk32("rst_mem_addr", bus.mem_addr, 32'h0);
    chk32("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk32("rst_if_rdata", bus.if_rdata, 32'h0);
    chk32("rst_d_rdata", bus.d_rdata, 32'h0);
    @(posedge clk); #1;
    chk1("rst_if_ready", bus.if_ready, 1'b0);
    chk1("rst_d_ready", bus.d_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0;
    rate_f = 0; rate_d = 0; log_s = "";
    env_mem[32'h0040_0000] = 32'h2008_0005;
    ref_mem[32'h0040_0000] = 32'h2008_0005;
    #2;
    do_reset();

    // Reset in the 2nd BUSY cycle of a load aborts it
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1001_0008;
    step();
    step();
    chk1("abort_pre_en", bus.mem_en, 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) step();
    chk32("abort_d_rdata", bus.d_rdata, 32'h0);

    // Single fetch
    log_s = "";
    bus.if_req = 1'b1; bus.if_addr = 32'h0040_0000;
    step(); chk1("fetch_en1", bus.mem_en, 1'b1);
    step(); chk1("fetch_en2", bus.mem_en, 1'b1);
    step();
    chk1("fetch_en3", bus.mem_en, 1'b0);
    chk1("fetch_rdy", bus.if_ready, 1'b1);
    chk32("fetch_rdata", bus.if_rdata, 32'h2008_0005);
    step();
    chk1("fetch_rdy_end", bus.if_ready, 1'b0);
    chk32("fetch_hold", bus.if_rdata, 32'h2008_0005);

    // Store
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1001_0004; bus.d_wdata = 32'hDEAD_BEEF;
    for (int i = 1; i <= 2; i++) begin
      step();
      chk1("store_we", bus.mem_we, 1'b1);
      chk32("store_addr", bus.mem_addr, 32'h1001_0004);
      chk32("store_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    end
    step();
    chk1("store_rdy", bus.d_ready, 1'b1);
    chk32("store_d_rdata", bus.d_rdata, 32'h0);
    step();

    // Simultaneous fetch and load: data first
    log_s = "";
    bus.if_req = 1'b1; bus.if_addr = 32'h0040_0004;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1001_0000;
    for (int i = 0; i < 20 && log_s.len() < 2; i++) step();
    chk_str("both_order", log_s, "di");
    step();

    // Continuous data traffic with fetch waiting
    log_s = "";
    rate_f = 100; rate_d = 100;
    bus.if_req = 1'b1; bus.if_addr = 32'h0040_0008;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1001_0004;
    for (int i = 0; i < 60 && log_s.len() < 6; i++) step();
    chk_str("starve_order", log_s.substr(0, 5), "ddddid");

    // Randomized mixed traffic
    rate_f = 35; rate_d = 50;
    for (int i = 0; i < 3000; i++) step();
    rate_f = 0; rate_d = 0;
    for (int i = 0; i < 12; i++) step();
    chk1("drain_idle", bus.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
